// File: rtl/alu_dpath_arb.sv
// alu_dpath_arb: round-robin arbiter that shares one combinational ALU datapath
// between three requesters (0 = ALU, 1 = BJP, 2 = AGU) and registers the result
// into a single-entry response slot with one-cycle latency.
module alu_dpath_arb #(
   parameter int XLEN = 32,
   parameter int OPW  = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        req_valid,
   output logic [2:0]        req_ready,
   input  logic [3*OPW-1:0]  req_op,
   input  logic [3*XLEN-1:0] req_op1,
   input  logic [3*XLEN-1:0] req_op2,
   output logic [OPW-1:0]    dp_op,
   output logic [XLEN-1:0]   dp_op1,
   output logic [XLEN-1:0]   dp_op2,
   input  logic [XLEN-1:0]   dp_res,
   output logic [2:0]        rsp_valid,
   input  logic [2:0]        rsp_ready,
   output logic [XLEN-1:0]   rsp_data
);

   logic            r_res_vld;
   logic [1:0]      r_res_id;
   logic [XLEN-1:0] r_res_data;
   logic [1:0]      r_rr_ptr;

   logic [1:0]      w_gidx;
   logic            w_any;
   logic [2:0]      w_grant;
   logic            w_sel_rdy;
   logic            w_slot_free;
   logic            w_accept;
   logic            w_drain;

   assign w_any = |req_valid;

   // Pick the first valid requester starting at the round-robin pointer, wrapping 2->0.
   always_comb begin
      w_gidx = 2'd0;
      case (r_rr_ptr)
         2'd1:    w_gidx = req_valid[1] ? 2'd1 : (req_valid[2] ? 2'd2 : 2'd0);
         2'd2:    w_gidx = req_valid[2] ? 2'd2 : (req_valid[0] ? 2'd0 : 2'd1);
         default: w_gidx = req_valid[0] ? 2'd0 : (req_valid[1] ? 2'd1 : 2'd2);
      endcase
   end

   assign w_grant = w_any ? (3'b001 << w_gidx) : 3'b000;

   // Ready bit of whichever requester the pending response is addressed to.
   always_comb begin
      w_sel_rdy = 1'b0;
      case (r_res_id)
         2'd1:    w_sel_rdy = rsp_ready[1];
         2'd2:    w_sel_rdy = rsp_ready[2];
         default: w_sel_rdy = rsp_ready[0];
      endcase
   end

   assign w_slot_free = ~r_res_vld | w_sel_rdy;
   // rst_n gates ready so nothing looks accepted while the block is held in reset.
   assign req_ready   = w_grant & {3{w_slot_free & rst_n}};
   assign w_accept    = |(req_valid & req_ready);
   assign w_drain     = r_res_vld & w_sel_rdy;

   // Route the granted requester's payload to the shared datapath; zero when idle.
   always_comb begin
      dp_op  = '0;
      dp_op1 = '0;
      dp_op2 = '0;
      if (w_accept) begin
         case (w_gidx)
            2'd1: begin
               dp_op  = req_op[OPW +: OPW];
               dp_op1 = req_op1[XLEN +: XLEN];
               dp_op2 = req_op2[XLEN +: XLEN];
            end
            2'd2: begin
               dp_op  = req_op[2*OPW +: OPW];
               dp_op1 = req_op1[2*XLEN +: XLEN];
               dp_op2 = req_op2[2*XLEN +: XLEN];
            end
            default: begin
               dp_op  = req_op[0 +: OPW];
               dp_op1 = req_op1[0 +: XLEN];
               dp_op2 = req_op2[0 +: XLEN];
            end
         endcase
      end
   end

   // Response slot and arbitration pointer; accept wins over drain so back-to-back transfers overlap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_vld  <= 1'b0;
         r_res_id   <= 2'd0;
         r_res_data <= '0;
         r_rr_ptr   <= 2'd0;
      end else if (w_accept) begin
         r_res_vld  <= 1'b1;
         r_res_id   <= w_gidx;
         r_res_data <= dp_res;
         r_rr_ptr   <= (w_gidx == 2'd2) ? 2'd0 : (w_gidx + 2'd1);
      end else if (w_drain) begin
         r_res_vld  <= 1'b0;
      end
   end

   assign rsp_valid[0] = r_res_vld & (r_res_id == 2'd0);
   assign rsp_valid[1] = r_res_vld & (r_res_id == 2'd1);
   assign rsp_valid[2] = r_res_vld & (r_res_id == 2'd2);
   assign rsp_data     = r_res_vld ? r_res_data : '0;

endmodule

// File: tb/tb_alu_dpath_arb.sv
// tb_alu_dpath_arb: directed vectors for the shared-ALU arbiter, checked against a
// transaction-level model every cycle plus literal expectations per scenario.
module tb_alu_dpath_arb;
   localparam int XLEN = 32;
   localparam int OPW  = 11;
   localparam logic [OPW-1:0] OP_ADD = 11'd1,   OP_SUB = 11'd2,   OP_XOR  = 11'd4;
   localparam logic [OPW-1:0] OP_SLL = 11'd8,   OP_SRL = 11'd16,  OP_SRA  = 11'd32;
   localparam logic [OPW-1:0] OP_OR  = 11'd64,  OP_AND = 11'd128, OP_SLT  = 11'd256;
   localparam logic [OPW-1:0] OP_LUI = 11'd1024;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [2:0]        req_valid, req_ready;
   logic [3*OPW-1:0]  req_op;
   logic [3*XLEN-1:0] req_op1, req_op2;
   logic [OPW-1:0]    dp_op;
   logic [XLEN-1:0]   dp_op1, dp_op2, dp_res;
   logic [2:0]        rsp_valid, rsp_ready;
   logic [XLEN-1:0]   rsp_data;

   int checks = 0;
   int failures = 0;

   alu_dpath_arb #(.XLEN(XLEN), .OPW(OPW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_op1(req_op1), .req_op2(req_op2),
      .dp_op(dp_op), .dp_op1(dp_op1), .dp_op2(dp_op2), .dp_res(dp_res),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
   );

   always #5 clk = ~clk;

   // Shared datapath stand-in: every selected op contributes (ORed), none selected gives 0.
   function automatic logic [XLEN-1:0] alu(input logic [OPW-1:0] op, input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      r = '0;
      if (op[0])  r |= a + b;
      if (op[1])  r |= a - b;
      if (op[2])  r |= a ^ b;
      if (op[3])  r |= a << b[4:0];
      if (op[4])  r |= a >> b[4:0];
      if (op[5])  r |= $unsigned($signed(a) >>> b[4:0]);
      if (op[6])  r |= a | b;
      if (op[7])  r |= a & b;
      if (op[8])  r |= {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      if (op[9])  r |= {{(XLEN-1){1'b0}}, (a < b)};
      if (op[10]) r |= b;
      return r;
   endfunction

   assign dp_res = alu(dp_op, dp_op1, dp_op2);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one pending response slot plus a round-robin pointer.
   bit              m_vld;
   int              m_id, m_ptr, g, idx;
   logic [XLEN-1:0] m_data;
   logic [2:0]      e_rdy, e_rsv;
   logic [OPW-1:0]  e_op;
   logic [XLEN-1:0] e_a, e_b;
   bit              free;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_vld = 0; m_id = 0; m_data = '0; m_ptr = 0;
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_data", rsp_data, 0);
         chk("rst_req_ready", req_ready, 0);
      end else begin
         g = -1;
         for (int k = 0; k < 3; k++) begin
            idx = (m_ptr + k) % 3;
            if (g < 0 && req_valid[idx]) g = idx;
         end
         free = !m_vld || rsp_ready[m_id];
         e_rdy = '0;
         if (g >= 0 && free) e_rdy[g] = 1'b1;
         e_rsv = '0;
         if (m_vld) e_rsv[m_id] = 1'b1;
         e_op = '0; e_a = '0; e_b = '0;
         if (e_rdy != 0) begin
            e_op = req_op[g*OPW +: OPW];
            e_a  = req_op1[g*XLEN +: XLEN];
            e_b  = req_op2[g*XLEN +: XLEN];
         end
         chk("model_req_ready", req_ready, e_rdy);
         chk("model_rsp_valid", rsp_valid, e_rsv);
         chk("model_rsp_data", rsp_data, m_vld ? m_data : '0);
         chk("model_dp_op", dp_op, e_op);
         chk("model_dp_op1", dp_op1, e_a);
         chk("model_dp_op2", dp_op2, e_b);
         if (e_rdy != 0) begin
            m_vld = 1; m_id = g; m_data = alu(e_op, e_a, e_b); m_ptr = (g + 1) % 3;
         end else if (m_vld && rsp_ready[m_id]) begin
            m_vld = 0;
         end
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic set_req(input int i, input logic [OPW-1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b);
      req_op[i*OPW +: OPW]    = op;
      req_op1[i*XLEN +: XLEN] = a;
      req_op2[i*XLEN +: XLEN] = b;
   endtask

   task automatic do_reset();
      cyc(); rst_n = 1'b0;
      cyc(); cyc(); rst_n = 1'b1;
   endtask

   logic [2:0] ord [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

   initial begin
      rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_op = '0; req_op1 = '0; req_op2 = '0;
      req_valid = 3'b111;
      @(posedge clk); #3;
      chk("reset_req_ready", req_ready, 3'b000);
      chk("reset_rsp_valid", rsp_valid, 3'b000);
      req_valid = '0;
      cyc(); rst_n = 1'b1;

      // single add request
      set_req(0, OP_ADD, 5, 7); req_valid = 3'b001; rsp_ready = 3'b111;
      #2 chk("t035_ready", req_ready, 3'b001); chk("t035_dp_op1", dp_op1, 5);
      cyc(); req_valid = '0;
      #2 chk("t035_rsp_valid", rsp_valid, 3'b001); chk("t035_rsp_data", rsp_data, 12);
      cyc();
      #2 chk("t035_idle", rsp_valid, 3'b000);

      // all three valid, full throughput
      do_reset();
      set_req(0, OP_SUB, 100, 30); set_req(1, OP_XOR, 32'hFF00, 32'h0FF0); set_req(2, OP_SLL, 3, 4);
      req_valid = 3'b111; rsp_ready = 3'b111;
      for (int i = 0; i < 6; i++) begin
         #2 chk("t036_grant", req_ready, ord[i]);
         cyc();
      end
      req_valid = '0;
      #2 chk("t036_last_rsp", rsp_data, 48);

      // backpressure on requester 1
      cyc();
      set_req(1, OP_OR, 32'hF0, 32'h0F); req_valid = 3'b010; rsp_ready = 3'b000;
      #2 chk("t037_accept", req_ready, 3'b010);
      cyc();
      set_req(1, OP_AND, 32'hFF, 32'h3C);
      for (int i = 0; i < 3; i++) begin
         #2 chk("t037_stall_ready", req_ready, 3'b000);
         chk("t037_stall_data", rsp_data, 32'hFF);
         chk("t037_stall_valid", rsp_valid, 3'b010);
         cyc();
      end
      rsp_ready = 3'b010;
      #2 chk("t037_resume_ready", req_ready, 3'b010);
      cyc(); req_valid = '0;
      #2 chk("t037_new_data", rsp_data, 32'h3C); chk("t037_new_valid", rsp_valid, 3'b010);

      // pointer at 2 with requesters 0 and 2 valid
      cyc();
      rsp_ready = 3'b111;
      set_req(0, OP_SLT, 32'hFFFF_FFFF, 1); set_req(2, OP_SRA, 32'h8000_0000, 4);
      req_valid = 3'b101;
      #2 chk("t038_first", req_ready, 3'b100);
      cyc(); req_valid = 3'b001;
      #2 chk("t038_second", req_ready, 3'b001); chk("t038_sra", rsp_data, 32'hF800_0000);
      cyc(); req_valid = 3'b111;
      #2 chk("t038_ptr1", req_ready, 3'b010); chk("t038_slt", rsp_data, 1);
      cyc(); req_valid = '0;

      // multi-hot and all-zero ops pass through unchecked
      cyc();
      set_req(0, OP_ADD | OP_XOR, 6, 3); req_valid = 3'b001;
      #2 chk("t031_op", dp_op, OP_ADD | OP_XOR);
      cyc(); req_valid = '0;
      #2 chk("t031_rsp", rsp_data, 32'hD);
      cyc();
      set_req(2, '0, 9, 9); req_valid = 3'b100;
      #2 chk("t031_zero_ready", req_ready, 3'b100);
      cyc(); req_valid = '0;
      #2 chk("t031_zero_valid", rsp_valid, 3'b100); chk("t031_zero_data", rsp_data, 0);

      // asynchronous reset with a response pending
      cyc();
      set_req(0, OP_LUI, 0, 32'h1234_5000); req_valid = 3'b001; rsp_ready = 3'b000;
      cyc(); req_valid = '0;
      chk("t039_pending", rsp_valid, 3'b001);
      #1 rst_n = 1'b0;
      #1 chk("t039_async_valid", rsp_valid, 3'b000); chk("t039_async_data", rsp_data, 0);
      cyc(); cyc(); rst_n = 1'b1;
      set_req(1, OP_SRL, 32'h100, 4); set_req(2, OP_SUB, 5, 7);
      req_valid = 3'b110; rsp_ready = 3'b111;
      #2 chk("t039_first_grant", req_ready, 3'b010);
      cyc(); req_valid = 3'b100;
      #2 chk("t039_second_grant", req_ready, 3'b100); chk("t039_srl", rsp_data, 32'h10);
      cyc(); req_valid = '0;
      #2 chk("t039_sub", rsp_data, 32'hFFFF_FFFE);
      cyc(); cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
